// File: rtl/e203_ifu_litebpu_sync.sv
// Static branch predictor for the IFU: taken flag, next-PC adder operands,
// and RF read-port-1 arbitration for JALR through a general register.
module e203_ifu_litebpu_sync #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               dec_i_valid,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [31:0]        dec_bjp_imm,
  input  logic [4:0]         dec_jalr_rs1idx,
  input  logic               oitf_empty,
  input  logic               ir_valid,
  input  logic               ir_rd_wen,
  input  logic [4:0]         ir_rdidx,
  input  logic               ir_rs1en,
  input  logic [XLEN-1:0]    rf2bpu_x1,
  input  logic [XLEN-1:0]    rf2bpu_rs1,
  output logic               bpu2rf_rs1_ena,
  output logic               bpu_wait,
  output logic               prdt_taken,
  output logic [PC_SIZE-1:0] prdt_pc_add_op1,
  output logic [PC_SIZE-1:0] prdt_pc_add_op2
);

  typedef enum logic {
    IDLE,
    RDRF
  } state_e;

  state_e state_q, state_d;

  logic jalr_v;
  logic idx_x0;
  logic idx_x1;
  logic x1_dep;
  logic xn_dep;

  always_comb begin
    jalr_v = dec_i_valid & dec_jalr;
    idx_x0 = (dec_jalr_rs1idx == 5'd0);
    idx_x1 = (dec_jalr_rs1idx == 5'd1);
    x1_dep = ~oitf_empty
           | (ir_valid & ir_rd_wen & (ir_rdidx == 5'd1));
    xn_dep = ~oitf_empty | ir_valid;
  end

  always_comb begin
    prdt_taken = dec_i_valid
               & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[31]));
    prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
    prdt_pc_add_op1 = pc;
    if (dec_jalr) begin
      unique case (1'b1)
        idx_x0:  prdt_pc_add_op1 = '0;
        idx_x1:  prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
        default: prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
      endcase
    end
  end

  // A read in flight (RDRF) always returns to IDLE; only IDLE can claim the port.
  always_comb begin
    state_d        = state_q;
    bpu_wait       = 1'b0;
    bpu2rf_rs1_ena = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (jalr_v & idx_x1) begin
          bpu_wait = x1_dep;
        end else if (jalr_v & ~idx_x0) begin
          bpu_wait       = 1'b1;
          bpu2rf_rs1_ena = ~xn_dep & ~ir_rs1en & ~flush & ~rst;
          if (bpu2rf_rs1_ena) begin
            state_d = RDRF;
          end
        end
      end
      RDRF: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_e203_ifu_litebpu_sync.sv
// Scoreboard bench for the lite BPU: directed scenarios plus an IFU-like
// random driver checked against a behavioural model.
module tb_e203_ifu_litebpu_sync;

  typedef struct packed {
    logic        ena;
    logic        bw;
    logic        tk;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dec_i_valid = 1'b0;
  logic [31:0] pc = 32'h8000_0000;
  logic        dec_jal = 1'b0;
  logic        dec_jalr = 1'b0;
  logic        dec_bxx = 1'b0;
  logic [31:0] dec_bjp_imm = 32'h44;
  logic [4:0]  dec_jalr_rs1idx = 5'd0;
  logic        oitf_empty = 1'b1;
  logic        ir_valid = 1'b0;
  logic        ir_rd_wen = 1'b0;
  logic [4:0]  ir_rdidx = 5'd0;
  logic        ir_rs1en = 1'b0;
  logic [31:0] rf2bpu_x1 = 32'h0;
  logic [31:0] rf2bpu_rs1 = 32'h0;
  logic        bpu2rf_rs1_ena;
  logic        bpu_wait;
  logic        prdt_taken;
  logic [31:0] prdt_pc_add_op1;
  logic [31:0] prdt_pc_add_op2;

  e203_ifu_litebpu_sync #(.PC_SIZE(32), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .dec_i_valid     (dec_i_valid),
    .pc              (pc),
    .dec_jal         (dec_jal),
    .dec_jalr        (dec_jalr),
    .dec_bxx         (dec_bxx),
    .dec_bjp_imm     (dec_bjp_imm),
    .dec_jalr_rs1idx (dec_jalr_rs1idx),
    .oitf_empty      (oitf_empty),
    .ir_valid        (ir_valid),
    .ir_rd_wen       (ir_rd_wen),
    .ir_rdidx        (ir_rdidx),
    .ir_rs1en        (ir_rs1en),
    .rf2bpu_x1       (rf2bpu_x1),
    .rf2bpu_rs1      (rf2bpu_rs1),
    .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
    .bpu_wait        (bpu_wait),
    .prdt_taken      (prdt_taken),
    .prdt_pc_add_op1 (prdt_pc_add_op1),
    .prdt_pc_add_op2 (prdt_pc_add_op2)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad = 0;
  bit    inflight_m = 1'b0;
  exp_t  last_e;

  // Reference: a read launched this cycle means data arrives next cycle,
  // during which nothing stalls and no new read may start.
  function automatic exp_t model();
    exp_t e;
    bit   jr;
    bit   xdep1;
    bit   xdepn;
    jr    = dec_i_valid && dec_jalr;
    xdep1 = !oitf_empty || (ir_valid && ir_rd_wen && ir_rdidx == 5'd1);
    xdepn = !oitf_empty || ir_valid;
    e.tk  = dec_i_valid && (dec_jal || dec_jalr || (dec_bxx && dec_bjp_imm[31]));
    e.op2 = dec_bjp_imm;
    if (!dec_jalr) e.op1 = pc;
    else if (dec_jalr_rs1idx == 0) e.op1 = 32'h0;
    else if (dec_jalr_rs1idx == 1) e.op1 = rf2bpu_x1;
    else e.op1 = rf2bpu_rs1;
    e.bw  = 1'b0;
    e.ena = 1'b0;
    if (!inflight_m && jr) begin
      if (dec_jalr_rs1idx == 1) e.bw = xdep1;
      else if (dec_jalr_rs1idx >= 2) begin
        e.bw  = 1'b1;
        e.ena = !xdepn && !ir_rs1en && !flush && !rst;
      end
    end
    return e;
  endfunction

  task automatic push(input string nm, input exp_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    inflight_m = e.ena;
    last_e = e;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic ena, input logic bw,
                     input logic tk, input logic [31:0] o1,
                     input logic [31:0] o2);
    exp_t e;
    e.ena = ena; e.bw = bw; e.tk = tk; e.op1 = o1; e.op2 = o2;
    push(nm, e);
  endtask

  task automatic mdl(input string nm);
    push(nm, model());
  endtask

  task automatic cmp1(input string nm, input string f,
                      input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h t=%0t", nm, f, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      cmp1(n, "ena", {31'b0, bpu2rf_rs1_ena}, {31'b0, e.ena});
      cmp1(n, "wait", {31'b0, bpu_wait}, {31'b0, e.bw});
      cmp1(n, "taken", {31'b0, prdt_taken}, {31'b0, e.tk});
      cmp1(n, "op1", prdt_pc_add_op1, e.op1);
      cmp1(n, "op2", prdt_pc_add_op2, e.op2);
    end
  end

  task automatic set_instr(input logic v, input logic j, input logic jr,
                           input logic b, input logic [4:0] idx,
                           input logic [31:0] p, input logic [31:0] imm);
    dec_i_valid = v; dec_jal = j; dec_jalr = jr; dec_bxx = b;
    dec_jalr_rs1idx = idx; pc = p; dec_bjp_imm = imm;
  endtask

  task automatic set_env(input logic oe, input logic iv, input logic wen,
                         input logic [4:0] rd, input logic rs1en);
    oitf_empty = oe; ir_valid = iv; ir_rd_wen = wen;
    ir_rdidx = rd; ir_rs1en = rs1en;
  endtask

  task automatic new_random_instr();
    int k;
    logic [4:0] idx;
    k   = $urandom_range(0, 9);
    idx = 5'($urandom_range(2, 31));
    if ($urandom_range(0, 2) == 0) idx = 5'($urandom_range(0, 1));
    set_instr(k != 0, k inside {[1:2]}, k inside {[3:6]}, k inside {[7:9]},
              idx, $urandom(), $urandom());
  endtask

  initial begin
    int guard;
    @(posedge clk);
    #1;
    lit("rst0", 0, 0, 0, 32'h8000_0000, 32'h44);
    lit("rst1", 0, 0, 0, 32'h8000_0000, 32'h44);
    rst = 1'b0;

    set_instr(1, 1, 0, 0, 5'd0, 32'h8000_0100, 32'h40);
    lit("jal", 0, 0, 1, 32'h8000_0100, 32'h40);
    set_instr(1, 0, 0, 1, 5'd0, 32'h8000_0200, 32'hFFFF_FFF0);
    lit("bxx_back", 0, 0, 1, 32'h8000_0200, 32'hFFFF_FFF0);
    set_instr(1, 0, 0, 1, 5'd0, 32'h8000_0204, 32'h10);
    lit("bxx_fwd", 0, 0, 0, 32'h8000_0204, 32'h10);
    set_instr(1, 0, 1, 0, 5'd0, 32'h8000_0208, 32'h8);
    lit("jalr_x0", 0, 0, 1, 32'h0, 32'h8);

    set_instr(1, 0, 1, 0, 5'd1, 32'h8000_0300, 32'h4);
    set_env(1, 1, 1, 5'd1, 0);
    rf2bpu_x1 = 32'h2000_0000;
    for (int i = 0; i < 3; i++) lit("x1_dep", 0, 1, 1, 32'h2000_0000, 32'h4);
    set_env(1, 0, 0, 5'd0, 0);
    lit("x1_go", 0, 0, 1, 32'h2000_0000, 32'h4);

    set_instr(1, 0, 1, 0, 5'd5, 32'h8000_0400, 32'h0);
    rf2bpu_rs1 = 32'hDEAD_0000;
    lit("x5_req", 1, 1, 1, 32'hDEAD_0000, 32'h0);
    rf2bpu_rs1 = 32'h1234_5678;
    lit("x5_rdrf", 0, 0, 1, 32'h1234_5678, 32'h0);
    set_env(1, 1, 0, 5'd0, 0);
    lit("x5_idle", 0, 1, 1, 32'h1234_5678, 32'h0);
    set_env(1, 0, 0, 5'd0, 0);
    set_instr(0, 0, 0, 0, 5'd0, 32'h8000_0500, 32'h0);
    lit("novalid", 0, 0, 0, 32'h8000_0500, 32'h0);

    set_instr(1, 0, 1, 0, 5'd5, 32'h8000_0600, 32'h0);
    set_env(1, 0, 0, 5'd0, 1);
    rf2bpu_rs1 = 32'h0BAD_F00D;
    lit("conf0", 0, 1, 1, 32'h0BAD_F00D, 32'h0);
    lit("conf1", 0, 1, 1, 32'h0BAD_F00D, 32'h0);
    set_env(1, 0, 0, 5'd0, 0);
    lit("conf_req", 1, 1, 1, 32'h0BAD_F00D, 32'h0);
    rf2bpu_rs1 = 32'h5555_AAAA;
    lit("conf_rd", 0, 0, 1, 32'h5555_AAAA, 32'h0);

    flush = 1'b1;
    lit("flush_req", 0, 1, 1, 32'h5555_AAAA, 32'h0);
    flush = 1'b0;
    rst = 1'b1;
    lit("rst_req", 0, 1, 1, 32'h5555_AAAA, 32'h0);
    rst = 1'b0;
    lit("retry_req", 1, 1, 1, 32'h5555_AAAA, 32'h0);
    rst = 1'b1;
    lit("rst_in_rdrf", 0, 0, 1, 32'h5555_AAAA, 32'h0);
    set_instr(0, 0, 0, 0, 5'd0, 32'h8000_0700, 32'h44);
    lit("rst_vals", 0, 0, 0, 32'h8000_0700, 32'h44);
    rst = 1'b0;
    set_instr(1, 0, 1, 0, 5'd7, 32'h8000_0704, 32'h0);
    set_env(1, 1, 0, 5'd0, 0);
    lit("post_rst_idle", 0, 1, 1, 32'h5555_AAAA, 32'h0);
    set_env(1, 0, 0, 5'd0, 0);
    lit("post_rst_req", 1, 1, 1, 32'h5555_AAAA, 32'h0);
    lit("post_rst_rd", 0, 0, 1, 32'h5555_AAAA, 32'h0);

    new_random_instr();
    for (int c = 0; c < 400; c++) begin
      set_env($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0);
      rf2bpu_x1  = $urandom();
      rf2bpu_rs1 = $urandom();
      flush = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      mdl("rand");
      if (flush || rst || !last_e.bw) new_random_instr();
    end
    flush = 1'b0;
    rst = 1'b0;

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
